// File: rtl/z80_io_master_pkg.sv
// Z80 I/O master shared definitions: FSM state codes, wait counter width,
// strobe idle level and the latched request bundle.
package z80_io_master_pkg;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_T1   = 3'd1;
    localparam logic [2:0] S_T2   = 3'd2;
    localparam logic [2:0] S_TW   = 3'd3;
    localparam logic [2:0] S_T3   = 3'd4;

    localparam int WAIT_W = 8;

    localparam logic STROBE_IDLE = 1'b1;

    typedef struct packed {
        logic        wr;
        logic [15:0] addr;
        logic [7:0]  wdata;
    } req_t;

endpackage

// File: rtl/z80_io_master_if.sv
// Host request/response handshake plus emulated Z80 bus, one bundle.
// master = the bus initiator, slave = harness and port decoder side.
interface z80_io_master_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_wr;
    logic [15:0] req_addr;
    logic [7:0]  req_wdata;

    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        rsp_claimed;
    logic        rsp_timeout;

    logic        z_clk;
    logic [15:0] z_a;
    logic [7:0]  z_d_out;
    logic        z_d_oe;
    logic [7:0]  z_d_in;
    logic        z_n_iorq;
    logic        z_n_rd;
    logic        z_n_wr;
    logic        z_n_m1;
    logic        z_n_wait;
    logic        z_iorqge;

    modport master (
        input  req_valid, req_wr, req_addr, req_wdata,
        input  z_d_in, z_n_wait, z_iorqge,
        output req_ready,
        output rsp_valid, rsp_rdata, rsp_claimed, rsp_timeout,
        output z_clk, z_a, z_d_out, z_d_oe,
        output z_n_iorq, z_n_rd, z_n_wr, z_n_m1
    );

    modport slave (
        output req_valid, req_wr, req_addr, req_wdata,
        output z_d_in, z_n_wait, z_iorqge,
        input  req_ready,
        input  rsp_valid, rsp_rdata, rsp_claimed, rsp_timeout,
        input  z_clk, z_a, z_d_out, z_d_oe,
        input  z_n_iorq, z_n_rd, z_n_wr, z_n_m1
    );

endinterface

// File: rtl/z80_io_master_timebase.sv
// Free-running T-state timebase: half-period divider, half bit and the
// registered emulated CPU clock (high in first half, low in second).
module z80_io_master_timebase #(
    parameter int HALF_DIV = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    output logic tick_o,
    output logic mid_tick_o,
    output logic bnd_tick_o,
    output logic z_clk_o
);

    localparam int DW = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
    localparam logic [DW-1:0] LAST = DW'(HALF_DIV - 1);

    logic [DW-1:0] div_q;
    logic          h_q;
    logic          zclk_q;

    assign tick_o     = (div_q == LAST);
    assign mid_tick_o = tick_o & ~h_q;
    assign bnd_tick_o = tick_o & h_q;
    assign z_clk_o    = zclk_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            div_q  <= '0;
            h_q    <= 1'b0;
            zclk_q <= 1'b1;
        end else begin
            div_q <= tick_o ? '0 : div_q + 1'b1;
            if (tick_o) begin
                h_q    <= ~h_q;
                // new z_clk is the inverse of the new half bit
                zclk_q <= h_q;
            end
        end
    end

endmodule

// File: rtl/z80_io_master.sv
// Z80 I/O bus initiator: turns a valid/ready request into a T1/T2/TW/T3
// I/O cycle; all bus outputs move only on timebase ticks.
module z80_io_master
    import z80_io_master_pkg::*;
#(
    parameter int HALF_DIV = 2,
    parameter int MAX_WAIT = 255
) (
    input logic            clk,
    input logic            rst,
    z80_io_master_if.master bus
);

    localparam logic [WAIT_W-1:0] MAXW = WAIT_W'(MAX_WAIT);

    logic tick, mid_tick, bnd_tick, z_clk;

    z80_io_master_timebase #(
        .HALF_DIV (HALF_DIV)
    ) u_tb (
        .clk_i      (clk),
        .rst_i      (rst),
        .tick_o     (tick),
        .mid_tick_o (mid_tick),
        .bnd_tick_o (bnd_tick),
        .z_clk_o    (z_clk)
    );

    logic [2:0]        state_q, state_d;
    req_t              req_q, req_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              more_q, more_d;
    logic              claim_q, claim_d;
    logic              tout_q, tout_d;
    logic [7:0]        rdata_q, rdata_d;
    logic [15:0]       a_q, a_d;
    logic [7:0]        dout_q, dout_d;
    logic              doe_q, doe_d;
    logic              n_iorq_q, n_iorq_d;
    logic              n_rd_q, n_rd_d;
    logic              n_wr_q, n_wr_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [7:0]        rsp_rdata_q, rsp_rdata_d;
    logic              rsp_claim_q, rsp_claim_d;
    logic              rsp_tout_q, rsp_tout_d;

    logic req_ready;
    logic accept;

    assign req_ready = (state_q == S_IDLE) && bnd_tick && !rst;
    assign accept    = bus.req_valid && req_ready;

    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        wait_d      = wait_q;
        more_d      = more_q;
        claim_d     = claim_q;
        tout_d      = tout_q;
        rdata_d     = rdata_q;
        a_d         = a_q;
        dout_d      = dout_q;
        doe_d       = doe_q;
        n_iorq_d    = n_iorq_q;
        n_rd_d      = n_rd_q;
        n_wr_d      = n_wr_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_claim_d = rsp_claim_q;
        rsp_tout_d  = rsp_tout_q;
        if (tick) begin
            unique case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        state_d = S_T1;
                        req_d   = '{wr: bus.req_wr,
                                    addr: bus.req_addr,
                                    wdata: bus.req_wdata};
                        a_d     = bus.req_addr;
                        claim_d = 1'b0;
                        tout_d  = 1'b0;
                        rdata_d = 8'h00;
                    end
                end
                S_T1: begin
                    if (mid_tick) begin
                        if (req_q.wr) begin
                            dout_d = req_q.wdata;
                            doe_d  = 1'b1;
                        end
                    end else begin
                        state_d  = S_T2;
                        n_iorq_d = ~STROBE_IDLE;
                        if (req_q.wr) n_wr_d = ~STROBE_IDLE;
                        else          n_rd_d = ~STROBE_IDLE;
                    end
                end
                S_T2: begin
                    if (bnd_tick) begin
                        state_d = S_TW;
                        wait_d  = 8'd1;
                    end
                end
                S_TW: begin
                    // decision is taken on the falling edge, applied at the boundary
                    if (mid_tick) begin
                        more_d = !bus.z_n_wait && (wait_q < MAXW);
                        tout_d = !bus.z_n_wait && !(wait_q < MAXW);
                        if (wait_q == 8'd1) claim_d = bus.z_iorqge;
                    end else if (more_q) begin
                        wait_d = wait_q + 8'd1;
                    end else begin
                        state_d = S_T3;
                    end
                end
                S_T3: begin
                    if (mid_tick) begin
                        if (!req_q.wr) rdata_d = bus.z_d_in;
                        n_iorq_d = STROBE_IDLE;
                        n_rd_d   = STROBE_IDLE;
                        n_wr_d   = STROBE_IDLE;
                    end else begin
                        state_d     = S_IDLE;
                        doe_d       = 1'b0;
                        rsp_valid_d = 1'b1;
                        rsp_rdata_d = rdata_q;
                        rsp_claim_d = claim_q;
                        rsp_tout_d  = tout_q;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            req_q       <= '0;
            wait_q      <= '0;
            more_q      <= 1'b0;
            claim_q     <= 1'b0;
            tout_q      <= 1'b0;
            rdata_q     <= 8'h00;
            a_q         <= 16'h0000;
            dout_q      <= 8'h00;
            doe_q       <= 1'b0;
            n_iorq_q    <= STROBE_IDLE;
            n_rd_q      <= STROBE_IDLE;
            n_wr_q      <= STROBE_IDLE;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 8'h00;
            rsp_claim_q <= 1'b0;
            rsp_tout_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            wait_q      <= wait_d;
            more_q      <= more_d;
            claim_q     <= claim_d;
            tout_q      <= tout_d;
            rdata_q     <= rdata_d;
            a_q         <= a_d;
            dout_q      <= dout_d;
            doe_q       <= doe_d;
            n_iorq_q    <= n_iorq_d;
            n_rd_q      <= n_rd_d;
            n_wr_q      <= n_wr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_claim_q <= rsp_claim_d;
            rsp_tout_q  <= rsp_tout_d;
        end
    end

    assign bus.req_ready   = req_ready;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_rdata   = rsp_rdata_q;
    assign bus.rsp_claimed = rsp_claim_q;
    assign bus.rsp_timeout = rsp_tout_q;
    assign bus.z_clk       = z_clk;
    assign bus.z_a         = a_q;
    assign bus.z_d_out     = dout_q;
    assign bus.z_d_oe      = doe_q;
    assign bus.z_n_iorq    = n_iorq_q;
    assign bus.z_n_rd      = n_rd_q;
    assign bus.z_n_wr      = n_wr_q;
    assign bus.z_n_m1      = STROBE_IDLE;

endmodule

// File: tb/tb_z80_io_master.sv
// Self-checking bench for z80_io_master: directed and random I/O cycles
// checked against cycle counts derived from T-state arithmetic.
module tb_z80_io_master;

    localparam int HDA = 2;
    localparam int MWA = 4;
    localparam int HDB = 1;
    localparam int MWB = 255;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    z80_io_master_if ia();
    z80_io_master_if ib();

    z80_io_master #(.HALF_DIV(HDA), .MAX_WAIT(MWA)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ia)
    );

    z80_io_master #(.HALF_DIV(HDB), .MAX_WAIT(MWB)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ib)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        bit         hung;
        int         rdy_wait;
        int         iorq_lo;
        int         rd_lo;
        int         wr_lo;
        int         oe_hi;
        int         oe_first;
        int         rsp_cnt;
        int         rsp_at;
        logic [7:0] rdata;
        logic       claimed;
        logic       timeout;
        bit         hold_bad;
        bit         a_bad;
        bit         dout_bad;
        bit         m1_bad;
        logic       zclk0;
    } obs_t;

    function automatic int n_tw(input int w, input int mw);
        return (w + 1 < mw) ? w + 1 : mw;
    endfunction

    task automatic init_inputs;
        ia.req_valid = 0; ia.req_wr = 0; ia.req_addr = 0; ia.req_wdata = 0;
        ia.z_d_in = 0; ia.z_n_wait = 1; ia.z_iorqge = 0;
        ib.req_valid = 0; ib.req_wr = 0; ib.req_addr = 0; ib.req_wdata = 0;
        ib.z_d_in = 0; ib.z_n_wait = 1; ib.z_iorqge = 0;
    endtask

    // One cycle on dut_a; the responder holds WAIT low for w TW samples,
    // releasing it after the (w+1)-th falling z_clk edge once IORQ is low.
    task automatic xfer_a(input logic wr, input logic [15:0] addr,
                          input logic [7:0] wd, input logic [7:0] din,
                          input logic ge, input int w, output obs_t o);
        int  n, c, falls;
        bit  seen;
        logic pz;
        o.hung = 0; o.rdy_wait = 0; o.iorq_lo = 0; o.rd_lo = 0; o.wr_lo = 0;
        o.oe_hi = 0; o.oe_first = -1; o.rsp_cnt = 0; o.rsp_at = -1;
        o.rdata = 0; o.claimed = 0; o.timeout = 0; o.hold_bad = 0;
        o.a_bad = 0; o.dout_bad = 0; o.m1_bad = 0; o.zclk0 = 0;
        @(negedge clk);
        ia.req_wr = wr; ia.req_addr = addr; ia.req_wdata = wd;
        ia.z_d_in = din; ia.z_iorqge = ge;
        ia.z_n_wait = (w > 0) ? 1'b0 : 1'b1;
        ia.req_valid = 1'b1;
        n = 0;
        while (ia.req_ready !== 1'b1 && n < 64) begin
            @(negedge clk); n++;
        end
        o.rdy_wait = n;
        if (ia.req_ready !== 1'b1) begin
            o.hung = 1; ia.req_valid = 0; ia.z_n_wait = 1;
            return;
        end
        @(negedge clk);
        ia.req_valid = 1'b0;
        o.zclk0 = ia.z_clk;
        c = 0; falls = 0; seen = 0; pz = ia.z_clk;
        while (c < 300 && !(o.rsp_cnt > 0 && c >= o.rsp_at + 8)) begin
            if (ia.z_n_iorq === 1'b0) begin o.iorq_lo++; seen = 1; end
            if (ia.z_n_rd === 1'b0) o.rd_lo++;
            if (ia.z_n_wr === 1'b0) o.wr_lo++;
            if (ia.z_d_oe === 1'b1) begin
                if (o.oe_hi == 0) o.oe_first = c;
                o.oe_hi++;
                if (ia.z_d_out !== wd) o.dout_bad = 1;
            end
            if (ia.z_a !== addr) o.a_bad = 1;
            if (ia.z_n_m1 !== 1'b1) o.m1_bad = 1;
            if (seen && pz === 1'b1 && ia.z_clk === 1'b0) begin
                falls++;
                if (falls == w + 1) ia.z_n_wait = 1'b1;
            end
            if (ia.rsp_valid === 1'b1) begin
                o.rsp_cnt++;
                if (o.rsp_cnt == 1) begin
                    o.rsp_at = c; o.rdata = ia.rsp_rdata;
                    o.claimed = ia.rsp_claimed; o.timeout = ia.rsp_timeout;
                end
            end
            pz = ia.z_clk;
            @(negedge clk); c++;
        end
        if (o.rsp_cnt == 0) o.hung = 1;
        else if (ia.rsp_rdata !== o.rdata || ia.rsp_claimed !== o.claimed ||
                 ia.rsp_timeout !== o.timeout) o.hold_bad = 1;
        ia.z_n_wait = 1'b1;
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        total++;
        if ({ia.z_clk, ia.z_n_iorq, ia.z_n_rd, ia.z_n_wr, ia.z_n_m1} !== 5'h1F) begin
            bad++; $display("FAIL rst_strobes got=%b want=11111",
                {ia.z_clk, ia.z_n_iorq, ia.z_n_rd, ia.z_n_wr, ia.z_n_m1});
        end
        total++;
        if ({ia.z_a, ia.z_d_out, ia.z_d_oe} !== 25'h0) begin
            bad++; $display("FAIL rst_bus got=%h/%h/%b want=0", ia.z_a, ia.z_d_out, ia.z_d_oe);
        end
        total++;
        if ({ia.req_ready, ia.rsp_valid, ia.rsp_rdata, ia.rsp_claimed, ia.rsp_timeout} !== 12'h0) begin
            bad++; $display("FAIL rst_rsp got=%b%b%h%b%b want=0", ia.req_ready, ia.rsp_valid,
                ia.rsp_rdata, ia.rsp_claimed, ia.rsp_timeout);
        end
        total++;
        if ({ib.z_clk, ib.req_ready, ib.z_n_iorq} !== 3'b101) begin
            bad++; $display("FAIL rst_b got=%b want=101", {ib.z_clk, ib.req_ready, ib.z_n_iorq});
        end
        rst = 1'b0;
    endtask

    task automatic test_write;
        obs_t o;
        xfer_a(1'b1, 16'hFFFD, 8'hFE, 8'h00, 1'b0, 0, o);
        total++; if (o.hung) begin bad++; $display("FAIL wr_hang got=1 want=0"); end
        total++; if (o.zclk0 !== 1'b1) begin bad++; $display("FAIL wr_zclk_t1 got=%b want=1", o.zclk0); end
        total++; if (o.wr_lo != 10) begin bad++; $display("FAIL wr_nwr got=%0d want=10", o.wr_lo); end
        total++; if (o.iorq_lo != 10) begin bad++; $display("FAIL wr_iorq got=%0d want=10", o.iorq_lo); end
        total++; if (o.rd_lo != 0) begin bad++; $display("FAIL wr_nrd got=%0d want=0", o.rd_lo); end
        total++; if (o.oe_hi != 14) begin bad++; $display("FAIL wr_oe got=%0d want=14", o.oe_hi); end
        total++; if (o.oe_first != HDA) begin bad++; $display("FAIL wr_oe_start got=%0d want=%0d", o.oe_first, HDA); end
        total++; if (o.rsp_at != 16) begin bad++; $display("FAIL wr_rsp_at got=%0d want=16", o.rsp_at); end
        total++; if (o.rsp_cnt != 1) begin bad++; $display("FAIL wr_rsp_cnt got=%0d want=1", o.rsp_cnt); end
        total++; if (o.a_bad || o.dout_bad || o.m1_bad) begin
            bad++; $display("FAIL wr_bus got=%b%b%b want=000", o.a_bad, o.dout_bad, o.m1_bad); end
        total++; if (o.rdata !== 8'h00) begin bad++; $display("FAIL wr_rdata got=%h want=00", o.rdata); end
    endtask

    task automatic test_read;
        obs_t o;
        xfer_a(1'b0, 16'h00CF, 8'h33, 8'h5A, 1'b1, 0, o);
        total++; if (o.rd_lo != 10) begin bad++; $display("FAIL rd_nrd got=%0d want=10", o.rd_lo); end
        total++; if (o.wr_lo != 0) begin bad++; $display("FAIL rd_nwr got=%0d want=0", o.wr_lo); end
        total++; if (o.oe_hi != 0) begin bad++; $display("FAIL rd_oe got=%0d want=0", o.oe_hi); end
        total++; if (o.rdata !== 8'h5A) begin bad++; $display("FAIL rd_data got=%h want=5a", o.rdata); end
        total++; if (o.claimed !== 1'b1) begin bad++; $display("FAIL rd_claim got=%b want=1", o.claimed); end
        total++; if (o.timeout !== 1'b0) begin bad++; $display("FAIL rd_tout got=%b want=0", o.timeout); end
    endtask

    task automatic test_wait;
        obs_t o;
        xfer_a(1'b1, 16'h00FB, 8'h81, 8'h00, 1'b0, 3, o);
        total++; if (o.wr_lo != (2 * 4 + 3) * HDA) begin
            bad++; $display("FAIL wait_nwr got=%0d want=%0d", o.wr_lo, (2 * 4 + 3) * HDA); end
        total++; if (o.rsp_at != 7 * 2 * HDA) begin
            bad++; $display("FAIL wait_rsp_at got=%0d want=%0d", o.rsp_at, 7 * 2 * HDA); end
        total++; if (o.timeout !== 1'b0) begin bad++; $display("FAIL wait_tout got=%b want=0", o.timeout); end
    endtask

    task automatic test_timeout;
        obs_t o;
        xfer_a(1'b0, 16'hBFFD, 8'h00, 8'hC3, 1'b0, 40, o);
        total++; if (o.rd_lo != (2 * MWA + 3) * HDA) begin
            bad++; $display("FAIL tout_nrd got=%0d want=%0d", o.rd_lo, (2 * MWA + 3) * HDA); end
        total++; if (o.timeout !== 1'b1) begin bad++; $display("FAIL tout_flag got=%b want=1", o.timeout); end
        total++; if (o.claimed !== 1'b0) begin bad++; $display("FAIL tout_claim got=%b want=0", o.claimed); end
        total++; if (o.rsp_cnt != 1) begin bad++; $display("FAIL tout_rsp_cnt got=%0d want=1", o.rsp_cnt); end
    endtask

    task automatic test_reset_mid;
        obs_t o;
        int   n, falls;
        logic pz;
        bit   rv;
        @(negedge clk);
        ia.req_wr = 1; ia.req_addr = 16'h00FB; ia.req_wdata = 8'h77;
        ia.z_n_wait = 0; ia.z_iorqge = 0; ia.req_valid = 1;
        n = 0;
        while (ia.req_ready !== 1'b1 && n < 64) begin @(negedge clk); n++; end
        @(negedge clk);
        ia.req_valid = 0;
        n = 0; falls = 0; pz = ia.z_clk;
        while (falls < 2 && n < 200) begin
            @(negedge clk); n++;
            if (ia.z_n_iorq === 1'b0 && pz === 1'b1 && ia.z_clk === 1'b0) falls++;
            pz = ia.z_clk;
        end
        total++; if ({ia.z_n_wr, ia.z_d_oe} !== 2'b01) begin
            bad++; $display("FAIL rstmid_pre got=%b want=01", {ia.z_n_wr, ia.z_d_oe}); end
        rst = 1'b1;
        #1;
        total++; if ({ia.z_n_iorq, ia.z_n_rd, ia.z_n_wr} !== 3'b111) begin
            bad++; $display("FAIL rstmid_strobes got=%b want=111", {ia.z_n_iorq, ia.z_n_rd, ia.z_n_wr}); end
        total++; if (ia.z_d_oe !== 1'b0) begin bad++; $display("FAIL rstmid_oe got=%b want=0", ia.z_d_oe); end
        rv = 0;
        repeat (4) begin @(negedge clk); if (ia.rsp_valid !== 1'b0) rv = 1; end
        rst = 1'b0;
        ia.z_n_wait = 1;
        repeat (40) begin @(negedge clk); if (ia.rsp_valid !== 1'b0) rv = 1; end
        total++; if (rv) begin bad++; $display("FAIL rstmid_rsp got=1 want=0"); end
        xfer_a(1'b0, 16'hFFFD, 8'h00, 8'hA5, 1'b1, 1, o);
        total++; if (o.rsp_cnt != 1 || o.rdata !== 8'hA5) begin
            bad++; $display("FAIL rstmid_after got=%0d/%h want=1/a5", o.rsp_cnt, o.rdata); end
        total++; if (o.rsp_at != 5 * 2 * HDA) begin
            bad++; $display("FAIL rstmid_lat got=%0d want=%0d", o.rsp_at, 5 * 2 * HDA); end
    endtask

    task automatic test_random;
        obs_t o;
        for (int k = 0; k < 12; k++) begin
            logic wr, ge;
            logic [15:0] addr;
            logic [7:0] wd, din;
            int w, nt, st;
            wr = 1'($urandom_range(0, 1)); ge = 1'($urandom_range(0, 1));
            addr = 16'($urandom); wd = 8'($urandom); din = 8'($urandom);
            w = int'($urandom_range(0, 6));
            xfer_a(wr, addr, wd, din, ge, w, o);
            nt = n_tw(w, MWA);
            st = (2 * nt + 3) * HDA;
            total++; if (o.hung || o.rdy_wait > 2 * HDA - 1) begin
                bad++; $display("FAIL rnd%0d_ready got=%0d/%0d want=0/<=%0d", k, o.hung, o.rdy_wait, 2 * HDA - 1); end
            total++; if ((wr ? o.wr_lo : o.rd_lo) != st || o.iorq_lo != st) begin
                bad++; $display("FAIL rnd%0d_strobe got=%0d/%0d want=%0d", k, wr ? o.wr_lo : o.rd_lo, o.iorq_lo, st); end
            total++; if ((wr ? o.rd_lo : o.wr_lo) != 0) begin
                bad++; $display("FAIL rnd%0d_other got=%0d want=0", k, wr ? o.rd_lo : o.wr_lo); end
            total++; if (o.oe_hi != (wr ? (3 + nt) * 2 * HDA - HDA : 0)) begin
                bad++; $display("FAIL rnd%0d_oe got=%0d want=%0d", k, o.oe_hi, wr ? (3 + nt) * 2 * HDA - HDA : 0); end
            total++; if (o.rsp_at != (3 + nt) * 2 * HDA || o.rsp_cnt != 1) begin
                bad++; $display("FAIL rnd%0d_rsp got=%0d/%0d want=%0d/1", k, o.rsp_at, o.rsp_cnt, (3 + nt) * 2 * HDA); end
            total++; if (o.rdata !== (wr ? 8'h00 : din)) begin
                bad++; $display("FAIL rnd%0d_rdata got=%h want=%h", k, o.rdata, wr ? 8'h00 : din); end
            total++; if (o.claimed !== ge || o.timeout !== (w >= MWA)) begin
                bad++; $display("FAIL rnd%0d_flags got=%b%b want=%b%b", k, o.claimed, o.timeout, ge, w >= MWA); end
            total++; if (o.a_bad || o.dout_bad || o.m1_bad || o.hold_bad) begin
                bad++; $display("FAIL rnd%0d_bus got=%b%b%b%b want=0000", k, o.a_bad, o.dout_bad, o.m1_bad, o.hold_bad); end
        end
    endtask

    task automatic test_back_to_back;
        for (int k = 0; k < 3; k++) begin
            logic [15:0] a1, a2;
            logic [7:0] d1, d2;
            logic [7:0] rd0, rd1;
            logic ge;
            int t, nh, nr, last, h0, h1, r0, r1;
            bit pa, pv;
            a1 = 16'($urandom); a2 = 16'($urandom);
            d1 = 8'($urandom); d2 = 8'($urandom);
            ge = 1'($urandom_range(0, 1));
            h0 = -100; h1 = -100; r0 = -100; r1 = -100; rd0 = 0; rd1 = 0;
            @(negedge clk);
            ib.req_wr = 0; ib.req_addr = a1; ib.z_d_in = d1;
            ib.z_iorqge = ge; ib.z_n_wait = 1; ib.req_valid = 1;
            t = 0; nh = 0; nr = 0; last = 0; pa = 0; pv = 0;
            while (t < 200 && !(nr >= 2 && t >= last + 6)) begin
                if (pa) begin ib.req_addr = a2; pa = 0; end
                if (pv) begin ib.req_valid = 0; pv = 0; end
                if (ib.req_valid === 1'b1 && ib.req_ready === 1'b1) begin
                    if (nh == 0) h0 = t; else if (nh == 1) h1 = t;
                    nh++;
                    if (nh == 1) pa = 1; else pv = 1;
                end
                if (ib.rsp_valid === 1'b1) begin
                    if (nr == 0) begin r0 = t; rd0 = ib.rsp_rdata; end
                    else if (nr == 1) begin r1 = t; rd1 = ib.rsp_rdata; end
                    nr++; last = t;
                    if (nr == 1) ib.z_d_in = d2;
                end
                @(negedge clk); t++;
            end
            ib.req_valid = 0;
            total++; if (nh != 2 || nr != 2) begin
                bad++; $display("FAIL b2b%0d_count got=%0d/%0d want=2/2", k, nh, nr); end
            total++; if (r0 - h0 != 1 + 4 * 2 * HDB || r1 - h1 != 1 + 4 * 2 * HDB) begin
                bad++; $display("FAIL b2b%0d_lat got=%0d/%0d want=%0d", k, r0 - h0, r1 - h1, 1 + 4 * 2 * HDB); end
            total++; if (h1 - r0 != 2 * HDB - 1) begin
                bad++; $display("FAIL b2b%0d_gap got=%0d want=%0d", k, h1 - r0, 2 * HDB - 1); end
            total++; if (rd0 !== d1 || rd1 !== d2) begin
                bad++; $display("FAIL b2b%0d_data got=%h/%h want=%h/%h", k, rd0, rd1, d1, d2); end
            total++; if (ib.rsp_claimed !== ge || ib.z_a !== a2) begin
                bad++; $display("FAIL b2b%0d_claim_addr got=%b/%h want=%b/%h", k, ib.rsp_claimed, ib.z_a, ge, a2); end
        end
    endtask

    initial begin
        init_inputs();
        test_reset();
        test_write();
        test_read();
        test_wait();
        test_timeout();
        test_reset_mid();
        test_random();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

endmodule
